// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-extension pipeline: mode encoding and rotate field width.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_DP   = 3'd0,
    IMM_MEM  = 3'd1,
    IMM_BR   = 3'd2,
    IMM_HALF = 3'd3,
    IMM_ZERO = 3'd4
  } imm_src_e;

  localparam int ROT_W = 4;
  localparam int SRC_W = 3;

endpackage

// File: rtl/ext_pipe_stage.sv
// One elastic pipeline slot: a valid bit plus a data register.
// Load and flush come from the surrounding pipe.
module ext_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         load,
  input  logic         vin,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Data only captures real entries; flush clears the valid bit and leaves data stale.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = vin;
      if (vin) data_d = d;
    end
    if (flush) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extension for decode->execute: field select in S1, rotate and final mux in S2,
// optional pure-delay S3. Elastic valid/ready with a pass-through tag.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int IMM_W  = 24,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IMM_W-1:0] imm,
  input  imm_src_e         imm_src,
  input  logic             carry_in,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] imm_ext,
  output logic             carry_out,
  output logic [TAG_W-1:0] out_tag
);

  localparam int MID_W = TAG_W + 1 + SRC_W + ROT_W + WIDTH;
  localparam int OUT_W = TAG_W + 1 + WIDTH;

  function automatic logic [WIDTH-1:0] sel_field(input logic [IMM_W-1:0] f, input imm_src_e src);
    logic [WIDTH-1:0] r;
    case (src)
      IMM_DP:   r = {{(WIDTH-8){1'b0}}, f[7:0]};
      IMM_MEM:  r = {{(WIDTH-12){1'b0}}, f[11:0]};
      IMM_BR:   r = {{(WIDTH-26){f[23]}}, f[23:0], 2'b00};
      IMM_HALF: r = {{(WIDTH-8){1'b0}}, f[11:8], f[3:0]};
      default:  r = '0;
    endcase
    return r;
  endfunction

  // Only DP rotates; rotating by 2*rot is a right rotate of the doubled word.
  function automatic logic [OUT_W-1:0] finish_op(input logic [WIDTH-1:0] field,
                                                 input logic [ROT_W-1:0] rot,
                                                 input imm_src_e         src,
                                                 input logic             cin,
                                                 input logic [TAG_W-1:0] tag);
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0]   res;
    logic               c;
    res = field;
    c   = cin;
    dbl = '0;
    if (src == IMM_DP) begin
      dbl = {field, field} >> {rot, 1'b0};
      res = dbl[WIDTH-1:0];
      if (rot != '0) c = res[WIDTH-1];
    end
    return {tag, c, res};
  endfunction

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] ld;
  logic [OUT_W-1:0]  last_q;

  // Stage k loads unless it and every stage after it are full while the output is blocked.
  always_comb begin : load_chain
    logic full;
    full = 1'b1;
    ld   = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full  = full & v[k];
      ld[k] = ~full | out_ready;
    end
  end

  generate
    if (STAGES == 1) begin : g_one
      logic [OUT_W-1:0] one_d;
      assign one_d = finish_op(sel_field(imm, imm_src), imm[11:8], imm_src, carry_in, in_tag);
      ext_pipe_stage #(.W(OUT_W)) u_s1 (
        .clk(clk), .reset(reset), .flush(flush), .load(ld[0]), .vin(in_valid),
        .d(one_d), .valid(v[0]), .q(last_q)
      );
    end else begin : g_multi
      logic [MID_W-1:0] s1_d, s1_q;
      logic [OUT_W-1:0] s2_d, s2_q;

      assign s1_d = {in_tag, carry_in, imm_src, imm[11:8], sel_field(imm, imm_src)};
      ext_pipe_stage #(.W(MID_W)) u_s1 (
        .clk(clk), .reset(reset), .flush(flush), .load(ld[0]), .vin(in_valid),
        .d(s1_d), .valid(v[0]), .q(s1_q)
      );

      assign s2_d = finish_op(s1_q[WIDTH-1:0],
                              s1_q[WIDTH +: ROT_W],
                              imm_src_e'(s1_q[WIDTH+ROT_W +: SRC_W]),
                              s1_q[WIDTH+ROT_W+SRC_W],
                              s1_q[MID_W-1 -: TAG_W]);
      ext_pipe_stage #(.W(OUT_W)) u_s2 (
        .clk(clk), .reset(reset), .flush(flush), .load(ld[1]), .vin(v[0]),
        .d(s2_d), .valid(v[1]), .q(s2_q)
      );

      if (STAGES == 3) begin : g_delay
        ext_pipe_stage #(.W(OUT_W)) u_s3 (
          .clk(clk), .reset(reset), .flush(flush), .load(ld[2]), .vin(v[1]),
          .d(s2_q), .valid(v[2]), .q(last_q)
        );
      end else begin : g_nodelay
        assign last_q = s2_q;
      end
    end
  endgenerate

  assign in_ready                       = ld[0];
  assign out_valid                      = v[STAGES-1];
  assign {out_tag, carry_out, imm_ext}  = last_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboarded bench for imm_extend_pipe: a 32-bit and a 64-bit instance run in lockstep.
module tb_imm_extend_pipe;
  import imm_pkg::*;

  logic        clk, reset, flush, in_valid, out_ready, carry_in;
  logic [23:0] imm;
  imm_src_e    imm_src;
  logic [3:0]  in_tag;

  logic        in_ready, out_valid, carry_out;
  logic [31:0] imm_ext;
  logic [3:0]  out_tag;
  logic        in_ready64, out_valid64, carry64;
  logic [63:0] imm_ext64;
  logic [3:0]  out_tag64;

  imm_extend_pipe #(.WIDTH(32), .IMM_W(24), .STAGES(2), .TAG_W(4)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .imm(imm), .imm_src(imm_src), .carry_in(carry_in), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .imm_ext(imm_ext),
    .carry_out(carry_out), .out_tag(out_tag)
  );

  imm_extend_pipe #(.WIDTH(64), .IMM_W(24), .STAGES(2), .TAG_W(4)) u_dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .imm(imm), .imm_src(imm_src), .carry_in(carry_in), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .imm_ext(imm_ext64),
    .carry_out(carry64), .out_tag(out_tag64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] e32;
    logic [63:0] e64;
    logic        c32;
    logic        c64;
    logic [3:0]  tag;
  } res_t;

  typedef struct {
    res_t exp;
    res_t obs;
    bit   unexp;
  } pair_t;

  res_t  exp_q[$];
  pair_t pairs[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    sync_err = 0;
  bit    drain_to;

  function automatic res_t model(input logic [23:0] im, input logic [2:0] src,
                                 input logic cin, input logic [3:0] tg);
    res_t r;
    int   n;
    r.tag = tg; r.c32 = cin; r.c64 = cin; r.e32 = '0; r.e64 = '0;
    case (src)
      3'd0: begin
        r.e32[7:0] = im[7:0];
        r.e64[7:0] = im[7:0];
        n = 2 * int'(im[11:8]);
        for (int i = 0; i < n; i++) begin
          r.e32 = {r.e32[0], r.e32[31:1]};
          r.e64 = {r.e64[0], r.e64[63:1]};
        end
        if (n != 0) begin r.c32 = r.e32[31]; r.c64 = r.e64[63]; end
      end
      3'd1: begin r.e32[11:0] = im[11:0]; r.e64[11:0] = im[11:0]; end
      3'd2: begin r.e32 = {{6{im[23]}}, im, 2'b00}; r.e64 = {{38{im[23]}}, im, 2'b00}; end
      3'd3: begin r.e32[7:0] = {im[11:8], im[3:0]}; r.e64[7:0] = {im[11:8], im[3:0]}; end
      default: ;
    endcase
    return r;
  endfunction

  task automatic drive(input logic [23:0] i, input logic [2:0] s, input logic c, input logic [3:0] t);
    in_valid = 1'b1; imm = i; imm_src = imm_src_e'(s); carry_in = c; in_tag = t;
  endtask

  // One clock of bookkeeping: handshakes sampled mid-cycle, returns at posedge+1.
  task automatic tick(output bit in_xfer);
    pair_t p;
    @(negedge clk);
    in_xfer = 1'b0;
    if (reset) begin
      if (in_ready64 !== in_ready || out_valid64 !== out_valid || out_tag64 !== out_tag) sync_err++;
      if (out_valid && out_ready && !flush) begin
        p.obs.e32 = imm_ext; p.obs.c32 = carry_out; p.obs.e64 = imm_ext64;
        p.obs.c64 = carry64; p.obs.tag = out_tag;
        p.unexp = (exp_q.size() == 0);
        if (!p.unexp) p.exp = exp_q.pop_front();
        pairs.push_back(p);
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) begin
        exp_q.push_back(model(imm, imm_src, carry_in, in_tag));
        in_xfer = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    bit x;
    int n;
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin tick(x); n++; end
    drain_to = (exp_q.size() != 0);
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, imm_ext, carry_out, out_tag} !== 38'd0) begin
      n_bad++;
      $display("FAIL reset_out32: got v=%b ext=%h c=%b tag=%h, want all 0", out_valid, imm_ext, carry_out, out_tag);
    end
    n_cmp++;
    if ({out_valid64, imm_ext64, carry64, out_tag64} !== 70'd0) begin
      n_bad++;
      $display("FAIL reset_out64: got v=%b ext=%h c=%b tag=%h, want all 0", out_valid64, imm_ext64, carry64, out_tag64);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_dp_latency;
    bit x;
    pairs.delete();
    out_ready = 1'b1;
    drive(24'h0004FF, 3'd0, 1'b0, 4'h1);
    tick(x);
    in_valid = 1'b0;
    n_cmp++;
    if ({x, out_valid} !== 2'b10) begin n_bad++; $display("FAIL dp_lat1: got xfer=%b out_valid=%b want 1,0", x, out_valid); end
    tick(x);
    n_cmp++;
    if ({out_valid, imm_ext, carry_out, imm_ext64} !== {1'b1, 32'hFF000000, 1'b1, 64'hFF00000000000000}) begin
      n_bad++;
      $display("FAIL dp_rot: got v=%b ext=%h c=%b ext64=%h want 1 FF000000 1 FF00000000000000", out_valid, imm_ext, carry_out, imm_ext64);
    end
    tick(x);
    drive(24'h00002A, 3'd0, 1'b1, 4'h2);
    tick(x);
    in_valid = 1'b0;
    tick(x);
    n_cmp++;
    if ({out_valid, imm_ext, carry_out} !== {1'b1, 32'h0000002A, 1'b1}) begin
      n_bad++;
      $display("FAIL dp_norot: got v=%b ext=%h c=%b want 1 0000002A 1", out_valid, imm_ext, carry_out);
    end
    drain(8);
    tick(x);
    n_cmp++;
    if (pairs.size() != 2 || drain_to) begin n_bad++; $display("FAIL dp_count: got %0d want 2", pairs.size()); end
    foreach (pairs[i]) begin
      n_cmp++;
      if (pairs[i].unexp || {pairs[i].obs.e32, pairs[i].obs.c32, pairs[i].obs.e64, pairs[i].obs.c64, pairs[i].obs.tag}
          !== {pairs[i].exp.e32, pairs[i].exp.c32, pairs[i].exp.e64, pairs[i].exp.c64, pairs[i].exp.tag}) begin
        n_bad++;
        $display("FAIL dp_sb[%0d]: got %h/%b/%h/%b/%h want %h/%b/%h/%b/%h", i, pairs[i].obs.e32, pairs[i].obs.c32,
                 pairs[i].obs.e64, pairs[i].obs.c64, pairs[i].obs.tag, pairs[i].exp.e32, pairs[i].exp.c32,
                 pairs[i].exp.e64, pairs[i].exp.c64, pairs[i].exp.tag);
      end
    end
  endtask

  typedef struct {
    logic [23:0] im; logic [2:0] src; logic cin;
    logic [31:0] k32; logic [63:0] k64; logic kc32; logic kc64;
  } vec_t;

  task automatic test_modes;
    vec_t tbl[9];
    bit   x;
    tbl[0] = '{24'hFFFFFE, 3'd2, 1'b0, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0, 1'b0};
    tbl[1] = '{24'h123ABC, 3'd1, 1'b1, 32'h00000ABC, 64'h0000000000000ABC, 1'b1, 1'b1};
    tbl[2] = '{24'h000A05, 3'd3, 1'b0, 32'h000000A5, 64'h00000000000000A5, 1'b0, 1'b0};
    tbl[3] = '{24'h000A05, 3'd3, 1'b1, 32'h000000A5, 64'h00000000000000A5, 1'b1, 1'b1};
    tbl[4] = '{24'hFFFFFF, 3'd4, 1'b1, 32'h00000000, 64'h0, 1'b1, 1'b1};
    tbl[5] = '{24'hABCDEF, 3'd7, 1'b0, 32'h00000000, 64'h0, 1'b0, 1'b0};
    tbl[6] = '{24'h000001, 3'd2, 1'b0, 32'h00000004, 64'h4, 1'b0, 1'b0};
    tbl[7] = '{24'h000F01, 3'd0, 1'b1, 32'h00000004, 64'h0000000400000000, 1'b0, 1'b0};
    tbl[8] = '{24'h000103, 3'd0, 1'b0, 32'hC0000000, 64'hC000000000000000, 1'b1, 1'b1};
    pairs.delete();
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].im, tbl[i].src, tbl[i].cin, 4'(i));
      tick(x);
    end
    drain(10);
    n_cmp++;
    if (pairs.size() != 9 || drain_to) begin n_bad++; $display("FAIL modes_count: got %0d want 9", pairs.size()); end
    foreach (pairs[i]) begin
      n_cmp++;
      if (pairs[i].unexp || {pairs[i].obs.e32, pairs[i].obs.c32, pairs[i].obs.e64, pairs[i].obs.c64, pairs[i].obs.tag}
          !== {tbl[i].k32, tbl[i].kc32, tbl[i].k64, tbl[i].kc64, 4'(i)}
          || {pairs[i].exp.e32, pairs[i].exp.c32, pairs[i].exp.e64, pairs[i].exp.c64}
          !== {pairs[i].obs.e32, pairs[i].obs.c32, pairs[i].obs.e64, pairs[i].obs.c64}) begin
        n_bad++;
        $display("FAIL modes[%0d]: got %h/%b/%h/%b/%h want %h/%b/%h/%b/%h", i, pairs[i].obs.e32, pairs[i].obs.c32,
                 pairs[i].obs.e64, pairs[i].obs.c64, pairs[i].obs.tag, tbl[i].k32, tbl[i].kc32, tbl[i].k64,
                 tbl[i].kc64, i);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit x;
    int sent, stalls, cyc;
    pairs.delete();
    out_ready = 1'b1;
    sent = 0; stalls = 0; cyc = 0;
    while (sent < 24 && cyc < 100) begin
      drive(24'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 4'(sent));
      #1;
      if (!in_ready) stalls++;
      tick(x);
      if (x) sent++;
      cyc++;
    end
    drain(10);
    n_cmp++;
    if (stalls != 0 || cyc != 24) begin n_bad++; $display("FAIL b2b_rate: got stalls=%0d cycles=%0d want 0 24", stalls, cyc); end
    n_cmp++;
    if (pairs.size() != 24 || drain_to) begin n_bad++; $display("FAIL b2b_count: got %0d want 24", pairs.size()); end
    foreach (pairs[i]) begin
      n_cmp++;
      if (pairs[i].unexp || {pairs[i].obs.e32, pairs[i].obs.c32, pairs[i].obs.e64, pairs[i].obs.c64, pairs[i].obs.tag}
          !== {pairs[i].exp.e32, pairs[i].exp.c32, pairs[i].exp.e64, pairs[i].exp.c64, pairs[i].exp.tag}) begin
        n_bad++;
        $display("FAIL b2b_sb[%0d]: got %h/%b/%h/%b/%h want %h/%b/%h/%b/%h", i, pairs[i].obs.e32, pairs[i].obs.c32,
                 pairs[i].obs.e64, pairs[i].obs.c64, pairs[i].obs.tag, pairs[i].exp.e32, pairs[i].exp.c32,
                 pairs[i].exp.e64, pairs[i].exp.c64, pairs[i].exp.tag);
      end
    end
  endtask

  task automatic test_backpressure;
    bit          x;
    int          sent;
    logic [36:0] held;
    pairs.delete();
    sent = 0;
    held = '0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      out_ready = !(cyc >= 2 && cyc <= 5);
      if (sent < 4) drive(24'($urandom), 3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'(sent + 1));
      else in_valid = 1'b0;
      #1;
      if (cyc == 2) begin
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_c2: got %b want 1", in_ready); end
      end
      if (cyc >= 3 && cyc <= 5) begin
        if (cyc == 3) held = {out_valid, imm_ext, out_tag};
        n_cmp++;
        if ({in_ready, out_valid, imm_ext, out_tag} !== {1'b0, held}) begin
          n_bad++;
          $display("FAIL bp_stall_c%0d: got rdy=%b v=%b ext=%h tag=%h want rdy=0 v=1 ext=%h tag=%h",
                   cyc, in_ready, out_valid, imm_ext, out_tag, held[35:4], held[3:0]);
        end
      end
      tick(x);
      if (x) sent++;
    end
    n_cmp++;
    if (pairs.size() != 4 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL bp_count: got %0d outputs, %0d pending, want 4 0", pairs.size(), exp_q.size());
    end
    foreach (pairs[i]) begin
      n_cmp++;
      if (pairs[i].unexp || pairs[i].obs.tag !== 4'(i + 1)
          || {pairs[i].obs.e32, pairs[i].obs.c32, pairs[i].obs.e64, pairs[i].obs.c64}
          !== {pairs[i].exp.e32, pairs[i].exp.c32, pairs[i].exp.e64, pairs[i].exp.c64}) begin
        n_bad++;
        $display("FAIL bp_order[%0d]: got tag=%h ext=%h want tag=%0d ext=%h", i, pairs[i].obs.tag,
                 pairs[i].obs.e32, i + 1, pairs[i].exp.e32);
      end
    end
  endtask

  task automatic test_flush;
    bit x;
    pairs.delete();
    out_ready = 1'b0;
    drive(24'h0004FF, 3'd0, 1'b0, 4'h1); tick(x);
    drive(24'h123ABC, 3'd1, 1'b0, 4'h2); tick(x);
    flush = 1'b1;
    drive(24'h000A05, 3'd3, 1'b1, 4'h9); tick(x);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin n_bad++; $display("FAIL flush_full: got v=%b rdy=%b want 0 1", out_valid, in_ready); end
    out_ready = 1'b1;
    drive(24'h00002A, 3'd0, 1'b1, 4'h3); tick(x);
    flush = 1'b1;
    drive(24'hFFFFFE, 3'd2, 1'b0, 4'hA); tick(x);
    flush = 1'b0; in_valid = 1'b0;
    tick(x);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_drop: got out_valid=%b want 0", out_valid); end
    drive(24'h000F01, 3'd0, 1'b0, 4'h5); tick(x);
    drive(24'h000A05, 3'd3, 1'b1, 4'h6); tick(x);
    drain(10);
    tick(x);
    n_cmp++;
    if (pairs.size() != 2 || drain_to) begin n_bad++; $display("FAIL flush_count: got %0d want 2", pairs.size()); end
    foreach (pairs[i]) begin
      n_cmp++;
      if (pairs[i].unexp || pairs[i].obs.tag !== 4'(i + 5)
          || {pairs[i].obs.e32, pairs[i].obs.c32, pairs[i].obs.e64, pairs[i].obs.c64}
          !== {pairs[i].exp.e32, pairs[i].exp.c32, pairs[i].exp.e64, pairs[i].exp.c64}) begin
        n_bad++;
        $display("FAIL flush_after[%0d]: got tag=%h ext=%h want tag=%0d ext=%h", i, pairs[i].obs.tag,
                 pairs[i].obs.e32, i + 5, pairs[i].exp.e32);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit x;
    pairs.delete();
    out_ready = 1'b1;
    drive(24'h0004FF, 3'd0, 1'b1, 4'h1); tick(x);
    drive(24'hFFFFFE, 3'd2, 1'b1, 4'h2); tick(x);
    drive(24'h123ABC, 3'd1, 1'b1, 4'h3); tick(x);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    n_cmp++;
    if ({out_valid, imm_ext, carry_out, out_tag, out_valid64, imm_ext64} !== 103'd0) begin
      n_bad++;
      $display("FAIL rst_mid: got v=%b ext=%h c=%b tag=%h v64=%b ext64=%h want all 0",
               out_valid, imm_ext, carry_out, out_tag, out_valid64, imm_ext64);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    tick(x); tick(x);
    n_cmp++;
    if (out_valid !== 1'b0 || pairs.size() != 1) begin
      n_bad++; $display("FAIL rst_replay: got out_valid=%b outputs=%0d want 0 1", out_valid, pairs.size());
    end
    drive(24'h000103, 3'd0, 1'b0, 4'h7); tick(x);
    drain(10);
    tick(x);
    n_cmp++;
    if (pairs.size() != 2 || drain_to) begin n_bad++; $display("FAIL rst_count: got %0d want 2", pairs.size()); end
    foreach (pairs[i]) begin
      n_cmp++;
      if (pairs[i].unexp || {pairs[i].obs.e32, pairs[i].obs.c32, pairs[i].obs.e64, pairs[i].obs.c64, pairs[i].obs.tag}
          !== {pairs[i].exp.e32, pairs[i].exp.c32, pairs[i].exp.e64, pairs[i].exp.c64, pairs[i].exp.tag}) begin
        n_bad++;
        $display("FAIL rst_sb[%0d]: got %h/%b/%h want %h/%b/%h", i, pairs[i].obs.e32, pairs[i].obs.c32,
                 pairs[i].obs.tag, pairs[i].exp.e32, pairs[i].exp.c32, pairs[i].exp.tag);
      end
    end
    n_cmp++;
    if (sync_err != 0) begin n_bad++; $display("FAIL lockstep_64: got %0d divergent cycles want 0", sync_err); end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    imm = '0; imm_src = IMM_DP; carry_in = 1'b0; in_tag = '0;
    test_reset;
    test_dp_latency;
    test_modes;
    test_back_to_back;
    test_backpressure;
    test_flush;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
